// File: rtl/ca_prng_pkg.sv
// ca_prng_pkg: shared state encoding and Rule-30 helpers for the CA PRNG scheduler.
package ca_prng_pkg;
  typedef enum logic {S_WARM, S_RUN} state_t;
  localparam int MAX_N = 64;
  localparam int IW = $clog2(MAX_N);
  // Width-generic step: operates on the low n bits of a MAX_N container, wrapping modulo n.
  function automatic logic [MAX_N-1:0] rule30_step(input logic [MAX_N-1:0] c, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[IW'(i)] = c[IW'((i + 1) % n)] ^ (c[IW'(i)] | c[IW'((i + n - 1) % n)]);
    return r;
  endfunction
  function automatic logic [MAX_N-1:0] default_seed(input int n);
    return MAX_N'(1) << (n / 2);
  endfunction
endpackage

// File: rtl/ca_prng_scheduler_core.sv
// ca_rule30_core: Rule-30 CA register with load and single-generation step.
module ca_rule30_core
  import ca_prng_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         step,
  output logic [N-1:0] state,
  output logic [N-1:0] next_state
);
  assign next_state = N'(rule30_step(MAX_N'(state), N));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= N'(default_seed(N));
    else if (load) state <= load_val;
    else if (step) state <= next_state;
endmodule

// File: rtl/ca_prng_scheduler.sv
// ca_prng_scheduler: round-robin sharing of one Rule-30 PRNG with seed/warm-up sequencing.
// Define CA_HEALTH_EN to add the stuck-state detector and sticky health_err.
module ca_prng_scheduler
  import ca_prng_pkg::*;
#(
  parameter int N      = 32,
  parameter int NREQ   = 4,
  parameter int WARMUP = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    seed_in,
  input  logic            seed_load,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    data_out,
  output logic            data_valid,
  output logic            ready,
  output logic            health_err
);
  localparam int CW = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [N-1:0] DSEED = N'(default_seed(N));
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] ptr, sel;
  logic [N-1:0] ca, ca_nxt, load_val;
  logic load, step, grant;
  ca_rule30_core #(.N(N)) u_core (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .step(step), .state(ca), .next_state(ca_nxt)
  );
  // Lowest offset after the pointer wins; scanning downward lets the last hit stand.
  always_comb begin
    sel = ptr;
    for (int o = NREQ; o >= 1; o--)
      if (req[PW'((int'(ptr) + o) % NREQ)]) sel = PW'((int'(ptr) + o) % NREQ);
  end
`ifdef CA_HEALTH_EN
  logic trip;
`endif
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    load = 1'b0;
    load_val = DSEED;
    step = 1'b0;
    grant = 1'b0;
    if (seed_load) begin
      load = 1'b1;
      load_val = seed_in == '0 ? DSEED : seed_in;
      cnt_n = '0;
      st_n = S_WARM;
    end else if (st == S_WARM) begin
      if (cnt == CW'(WARMUP)) st_n = S_RUN;
      else begin
        step = 1'b1;
        cnt_n = cnt + CW'(1);
      end
    end else if (|req) begin
      step = 1'b1;
      grant = 1'b1;
    end
`ifdef CA_HEALTH_EN
    trip = step && ca_nxt == ca;
    if (trip) begin
      load = 1'b1;
      load_val = DSEED;
      step = 1'b0;
      grant = 1'b0;
      cnt_n = '0;
      st_n = S_WARM;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= S_WARM;
      cnt <= '0;
      ptr <= PW'(NREQ - 1);
      gnt <= '0;
      data_out <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      gnt <= grant ? NREQ'(1) << sel : '0;
      if (grant) begin
        data_out <= ca;
        ptr <= sel;
      end
    end
`ifdef CA_HEALTH_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) health_err <= 1'b0;
    else if (trip) health_err <= 1'b1;
`else
  assign health_err = 1'b0;
`endif
  assign ready = st == S_RUN;
  assign data_valid = |gnt;
endmodule

// File: tb/tb_ca_prng_scheduler.sv
// tb_ca_prng_scheduler: directed vectors plus a per-cycle reference model of the PRNG scheduler.
module tb_ca_prng_scheduler;
`ifdef CA_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] seed_in = '0;
  logic seed_load = 1'b0, seed_load_w = 1'b0, poke = 1'b0;
  logic [3:0] req = '0, req_w = '0;
  logic [3:0] gnt, gnt_w;
  logic [7:0] data_out, data_w;
  logic data_valid, valid_w, ready, ready_w, health_err, health_w;
  int n_chk = 0, n_fail = 0;

  ca_prng_scheduler #(.N(8), .NREQ(4), .WARMUP(0)) dut (
    .clk(clk), .reset_n(reset_n), .seed_in(seed_in), .seed_load(seed_load), .req(req),
    .gnt(gnt), .data_out(data_out), .data_valid(data_valid), .ready(ready), .health_err(health_err)
  );
  ca_prng_scheduler #(.N(8), .NREQ(4), .WARMUP(3)) dut_w (
    .clk(clk), .reset_n(reset_n), .seed_in(seed_in), .seed_load(seed_load_w), .req(req_w),
    .gnt(gnt_w), .data_out(data_w), .data_valid(valid_w), .ready(ready_w), .health_err(health_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Rule 30 by whole-word rotation: right neighbour, self, left neighbour.
  function automatic logic [7:0] r30(input logic [7:0] c);
    return {c[0], c[7:1]} ^ (c | {c[6:0], c[7]});
  endfunction
  function automatic logic [1:0] owner(input logic [3:0] r, input logic [1:0] p);
    for (int o = 1; o <= 4; o++) if (r[(p + o) % 4]) return 2'((p + o) % 4);
    return p;
  endfunction

  logic [7:0] m_ca, e_data, cur;
  logic [3:0] e_gnt;
  logic [1:0] m_ptr;
  logic e_ready, e_health;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_ca <= 8'h10; m_ptr <= 2'd3; e_gnt <= '0; e_data <= '0; e_ready <= 1'b0; e_health <= 1'b0;
    end else begin
      cur = poke ? 8'h00 : m_ca;
      e_gnt <= '0;
      m_ca <= cur;
      if (seed_load) begin
        m_ca <= seed_in == 8'h00 ? 8'h10 : seed_in;
        e_ready <= 1'b0;
      end else if (!e_ready) e_ready <= 1'b1;
      else if (|req) begin
        if (HEALTH && r30(cur) == cur) begin
          e_health <= 1'b1; m_ca <= 8'h10; e_ready <= 1'b0;
        end else begin
          e_gnt <= 4'b1 << owner(req, m_ptr);
          e_data <= cur;
          m_ca <= r30(cur);
          m_ptr <= owner(req, m_ptr);
        end
      end
    end

  always @(negedge clk)
    if (reset_n) begin
      chk("m_gnt", gnt, e_gnt);
      chk("m_valid", data_valid, |e_gnt);
      chk("m_data", data_out, e_data);
      chk("m_ready", ready, e_ready);
      chk("m_health", health_err, e_health);
    end

  task automatic nxt; @(negedge clk); endtask

  logic [3:0] g_rr [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0] d_rr [5] = '{8'h10, 8'h38, 8'h64, 8'hDE, 8'h90};

  initial begin
    repeat (2) nxt;
    chk("rst_gnt", gnt, 0); chk("rst_valid", data_valid, 0); chk("rst_data", data_out, 0);
    chk("rst_ready", ready, 0); chk("rst_health", health_err, 0);
    reset_n = 1'b1;
    nxt;
    chk("run_ready", ready, 1);
    // round robin from the reset pointer with the default seed
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      nxt;
      chk("rr_gnt", gnt, g_rr[i]);
      chk("rr_data", data_out, d_rr[i]);
    end
    req = '0;
    // explicit seed, single requester
    seed_in = 8'h10; seed_load = 1'b1; req = 4'b0001;
    nxt;
    seed_load = 1'b0;
    chk("seed_ready", ready, 0); chk("seed_gnt", gnt, 0);
    nxt;
    chk("seed_gnt2", gnt, 0);
    nxt;
    chk("step_d0", data_out, 8'h10); chk("step_g0", gnt, 1);
    nxt;
    chk("step_d1", data_out, 8'h38);
    req = '0;
    // zero seed falls back to the default seed
    seed_in = 8'h00; seed_load = 1'b1;
    nxt;
    seed_load = 1'b0; req = 4'b0001;
    nxt;
    nxt;
    chk("zero_data", data_out, 8'h10);
    req = '0;
    // reseed while grants are streaming
    req = 4'hF;
    repeat (2) nxt;
    seed_in = 8'hA5; seed_load = 1'b1;
    nxt;
    seed_load = 1'b0;
    chk("reseed_gnt", gnt, 0); chk("reseed_ready", ready, 0);
    nxt;
    nxt;
    chk("reseed_owner", gnt, 4'h8); chk("reseed_data", data_out, 8'hA5);
    req = '0;
    // stuck all-zero CA
    nxt;
    force dut.u_core.state = 8'h00;
    poke = 1'b1; req = 4'b0001;
    #1 release dut.u_core.state;
    nxt;
    poke = 1'b0; req = '0;
    chk("stuck_health", health_err, HEALTH);
    chk("stuck_gnt", gnt, HEALTH ? 4'h0 : 4'h1);
    nxt;
    req = 4'b0001;
    nxt;
    chk("stuck_after", data_out, HEALTH ? 8'h10 : 8'h00);
    req = 4'hF;
    nxt;
    // asynchronous reset in the middle of a grant
    @(posedge clk);
    #1 chk("pre_rst_valid", data_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0); chk("arst_valid", data_valid, 0);
    chk("arst_data", data_out, 0); chk("arst_ready", ready, 0);
    req = '0;
    nxt;
    reset_n = 1'b1;
    repeat (6) nxt;
    // warm-up of three generations on the second instance
    seed_in = 8'h10; seed_load_w = 1'b1; req_w = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      nxt;
      seed_load_w = 1'b0;
      chk("warm_ready", ready_w, i == 5);
      chk("warm_gnt", gnt_w, 0);
    end
    nxt;
    chk("warm_gnt1", gnt_w, 4'h1);
    chk("warm_data", data_w, 8'hDE);
    req_w = '0;
    nxt;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
